pool_layer_sequencer: RTL and testbench

Sequences one 2×2/stride-2 pooling layer of the CNN over every window of every input feature map. For each window it drives a request/acknowledge handshake to the DMA read path, starts the pooling unit, and requests the DMA write-back of the result. It replaces the nested pooling loops in the CNN top-level controller: the top issues one `start` per pooling layer and waits for `done`. Pixel data never passes through this block; it handles only sequencing and address generation.

---
 rtl/cnn_pkg.sv | 19 +
 rtl/pool_addr_gen.sv | 80 ++++++++
 rtl/pool_layer_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pool_layer_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN controller definitions.
//   pool_seq_state_t : state encoding of pool_layer_sequencer
//   CNN_ADDR_W       : default memory address width
//   CNN_MAX_MAP      : largest supported feature-map edge
package cnn_pkg;

    localparam int CNN_ADDR_W  = 16;
    localparam int CNN_MAX_MAP = 32;

    typedef enum logic [2:0] {
        PS_IDLE,
        PS_RD,
        PS_POOL,
        PS_WR,
        PS_ADV,
        PS_FIN
    } pool_seq_state_t;

endpackage

// File: rtl/pool_addr_gen.sv
// Window counters and DMA address registers for the 2x2/stride-2 pooling walk.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   init                : latch map_size/map_count, load base addresses, clear counters
//   step                : advance to the next window (x innermost, then y, then map)
//   map_size, map_count : layer configuration, sampled on init
//   src_base, dst_base  : first read / write address, sampled on init
//   rd_addr, wr_addr    : current window top-left address / current result address
//   last                : current window is the final window of the layer
module pool_addr_gen
    import cnn_pkg::*;
#(
    parameter int ADDR_W = CNN_ADDR_W,
    parameter int SIZE_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              step,
    input  logic [SIZE_W-1:0] map_size,
    input  logic [CNT_W-1:0]  map_count,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last
);

    logic [SIZE_W-1:0] size_q;
    logic [SIZE_W-1:0] x;
    logic [SIZE_W-1:0] y;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  map;
    logic              x_end;
    logic              y_end;

    // Coordinates only take even values, so ">= S-2" marks the last column/row.
    assign x_end = (x >= size_q - SIZE_W'(2));
    assign y_end = (y >= size_q - SIZE_W'(2));
    assign last  = x_end && y_end && (map == count_q - CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            size_q  <= '0;
            count_q <= '0;
            x       <= '0;
            y       <= '0;
            map     <= '0;
            rd_addr <= '0;
            wr_addr <= '0;
        end else if (init) begin
            size_q  <= map_size;
            count_q <= map_count;
            x       <= '0;
            y       <= '0;
            map     <= '0;
            rd_addr <= src_base;
            wr_addr <= dst_base;
        end else if (step) begin
            wr_addr <= wr_addr + ADDR_W'(1);
            if (!x_end) begin
                x       <= x + SIZE_W'(2);
                rd_addr <= rd_addr + ADDR_W'(2);
            end else begin
                // Skipping 2+S from the last column lands on the next row pair,
                // and from the last row pair on the next map's base.
                x       <= '0;
                rd_addr <= rd_addr + ADDR_W'(size_q) + ADDR_W'(2);
                if (!y_end) begin
                    y <= y + SIZE_W'(2);
                end else begin
                    y   <= '0;
                    map <= map + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pool_layer_sequencer.sv
// Sequences one 2x2/stride-2 pooling layer over every window of every map:
// DMA read request, pooling-unit start, DMA write request, advance.
// Optional feature macro: POOL_SEQ_PERF_EN adds the perf_stall counter port.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   start, abort               : layer start (IDLE only), synchronous cancel
//   map_count, map_size        : number of maps / map edge S, sampled at start
//   src_base, dst_base         : map 0 pixel (0,0) address / first output address
//   rd_req, rd_ack, rd_addr    : DMA window read handshake
//   pool_start, pool_finish    : pooling unit handshake
//   wr_req, wr_ack, wr_addr    : DMA result write handshake
//   perf_stall                 : (POOL_SEQ_PERF_EN) cycles waiting on ack/finish
//   busy, done, err, aborted   : status; done/err/aborted are one-cycle pulses
module pool_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int ADDR_W = CNN_ADDR_W,
    parameter int SIZE_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  map_count,
    input  logic [SIZE_W-1:0] map_size,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              rd_req,
    input  logic              rd_ack,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pool_start,
    input  logic              pool_finish,
    output logic              wr_req,
    input  logic              wr_ack,
    output logic [ADDR_W-1:0] wr_addr,
`ifdef POOL_SEQ_PERF_EN
    output logic [31:0]       perf_stall,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              aborted
);

    pool_seq_state_t state;
    pool_seq_state_t state_nx;

    logic accept;
    logic cfg_ok;
    logic active;
    logic last;
    logic init;
    logic step;

    logic rd_req_nx;
    logic pool_start_nx;
    logic wr_req_nx;
    logic busy_nx;
    logic done_nx;
    logic err_nx;
    logic aborted_nx;

    assign cfg_ok = (map_size != '0) && !map_size[0]
                 && (int'(map_size) <= CNN_MAX_MAP)
                 && (map_count != '0);
    assign accept = (state == PS_IDLE) && start;
    assign active = state inside {PS_RD, PS_POOL, PS_WR, PS_ADV};
    assign init   = accept && cfg_ok;
    assign step   = (state == PS_ADV) && !abort;

    pool_addr_gen #(
        .ADDR_W (ADDR_W),
        .SIZE_W (SIZE_W),
        .CNT_W  (CNT_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .step      (step),
        .map_size  (map_size),
        .map_count (map_count),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .rd_addr   (rd_addr),
        .wr_addr   (wr_addr),
        .last      (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= PS_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            PS_IDLE: if (start) state_nx = cfg_ok ? PS_RD : PS_FIN;
            PS_RD:   if (abort) state_nx = PS_FIN; else if (rd_ack)      state_nx = PS_POOL;
            PS_POOL: if (abort) state_nx = PS_FIN; else if (pool_finish) state_nx = PS_WR;
            PS_WR:   if (abort) state_nx = PS_FIN; else if (wr_ack)      state_nx = PS_ADV;
            PS_ADV:  state_nx = (abort || last) ? PS_FIN : PS_RD;
            PS_FIN:  state_nx = PS_IDLE;
            default: state_nx = PS_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next state.
    always_comb begin
        rd_req_nx     = (state_nx == PS_RD);
        pool_start_nx = (state_nx == PS_POOL);
        wr_req_nx     = (state_nx == PS_WR);
        busy_nx       = (state_nx != PS_IDLE);
        done_nx       = (state_nx == PS_FIN);
        err_nx        = accept && !cfg_ok;
        aborted_nx    = active && abort;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_req     <= 1'b0;
            pool_start <= 1'b0;
            wr_req     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            rd_req     <= rd_req_nx;
            pool_start <= pool_start_nx;
            wr_req     <= wr_req_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            err        <= err_nx;
            aborted    <= aborted_nx;
        end
    end

`ifdef POOL_SEQ_PERF_EN
    logic stall;

    always_comb begin
        stall = 1'b0;
        unique case (state)
            PS_RD:   stall = !rd_ack;
            PS_POOL: stall = !pool_finish;
            PS_WR:   stall = !wr_ack;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall <= '0;
        end else if (accept) begin
            perf_stall <= '0;
        end else if (stall) begin
            perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pool_layer_sequencer.sv
// Self-checking bench for pool_layer_sequencer: table of layer configurations
// with a scoreboard of expected read/write addresses, plus hand-written abort
// and mid-operation reset sequences. Honors POOL_SEQ_PERF_EN when defined.
module tb_pool_layer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  map_count;
    logic [5:0]  map_size;
    logic [15:0] src_base;
    logic [15:0] dst_base;
    logic        rd_req;
    logic        rd_ack;
    logic [15:0] rd_addr;
    logic        pool_start;
    logic        pool_finish;
    logic        wr_req;
    logic        wr_ack;
    logic [15:0] wr_addr;
`ifdef POOL_SEQ_PERF_EN
    logic [31:0] perf_stall;
`endif
    logic        busy;
    logic        done;
    logic        err;
    logic        aborted;

    always #5 clk = ~clk;

    pool_layer_sequencer #(
        .ADDR_W (16),
        .SIZE_W (6),
        .CNT_W  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .map_count   (map_count),
        .map_size    (map_size),
        .src_base    (src_base),
        .dst_base    (dst_base),
        .rd_req      (rd_req),
        .rd_ack      (rd_ack),
        .rd_addr     (rd_addr),
        .pool_start  (pool_start),
        .pool_finish (pool_finish),
        .wr_req      (wr_req),
        .wr_ack      (wr_ack),
        .wr_addr     (wr_addr),
`ifdef POOL_SEQ_PERF_EN
        .perf_stall  (perf_stall),
`endif
        .busy        (busy),
        .done        (done),
        .err         (err),
        .aborted     (aborted)
    );

    typedef struct {
        int unsigned size;
        int unsigned maps;
        logic [15:0] src;
        logic [15:0] dst;
        int unsigned rl;
        int unsigned pl;
        int unsigned wl;
        bit          exp_err;
        int unsigned cycles;
        int unsigned stall;
    } vec_t;

    vec_t vecs[11];

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] rd_q[$];
    logic [15:0] wr_q[$];

    // Responder latencies: cycles a request is held before it is acknowledged.
    int unsigned rd_lat = 0, pool_lat = 0, wr_lat = 0;
    int unsigned rd_cnt = 0, pool_cnt = 0, wr_cnt = 0;
    int unsigned rd_seen = 0, wr_seen = 0, pool_hs = 0, pool_rise = 0;
    bit          rd_pend = 0, wr_pend = 0, prev_pool = 0;
    logic [15:0] prev_rd_addr = '0, prev_wr_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: wait for the falling edge, check held requests, score any
    // handshake that will complete on the next rising edge, drive the acks.
    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            rd_ack = 1'b0; pool_finish = 1'b0; wr_ack = 1'b0;
            rd_cnt = 0; pool_cnt = 0; wr_cnt = 0;
            rd_pend = 0; wr_pend = 0; prev_pool = 0;
        end else begin
            if (rd_pend) begin
                check("rd_req_held", rd_req, 1);
                check("rd_addr_stable", rd_addr, prev_rd_addr);
            end
            if (wr_pend) begin
                check("wr_req_held", wr_req, 1);
                check("wr_addr_stable", wr_addr, prev_wr_addr);
            end
            if (rd_req) begin
                rd_seen++;
                rd_ack = (rd_cnt >= rd_lat);
                rd_cnt++;
                if (rd_ack) begin
                    check("rd_expected", rd_q.size() != 0, 1);
                    if (rd_q.size() != 0) check("rd_addr", rd_addr, rd_q.pop_front());
                end
            end else begin
                rd_ack = 1'b0;
                rd_cnt = 0;
            end
            if (pool_start) begin
                if (!prev_pool) pool_rise++;
                pool_finish = (pool_cnt >= pool_lat);
                pool_cnt++;
                if (pool_finish) pool_hs++;
            end else begin
                pool_finish = 1'b0;
                pool_cnt = 0;
            end
            if (wr_req) begin
                wr_seen++;
                wr_ack = (wr_cnt >= wr_lat);
                wr_cnt++;
                if (wr_ack) begin
                    check("wr_expected", wr_q.size() != 0, 1);
                    if (wr_q.size() != 0) check("wr_addr", wr_addr, wr_q.pop_front());
                end
            end else begin
                wr_ack = 1'b0;
                wr_cnt = 0;
            end
            rd_pend = rd_req && !rd_ack;
            wr_pend = wr_req && !wr_ack;
            prev_rd_addr = rd_addr;
            prev_wr_addr = wr_addr;
            prev_pool = pool_start;
        end
    endtask

    // Reference walk written as a direct address formula.
    task automatic push_model(input int unsigned s, input int unsigned maps,
                              input logic [15:0] src, input logic [15:0] dst,
                              output int unsigned n);
        n = 0;
        for (int unsigned m = 0; m < maps; m++)
            for (int unsigned y = 0; y < s; y += 2)
                for (int unsigned x = 0; x < s; x += 2) begin
                    rd_q.push_back(16'(src + m * s * s + y * s + x));
                    wr_q.push_back(16'(dst + n));
                    n++;
                end
    endtask

    task automatic drive_start(input int unsigned s, input int unsigned maps,
                               input logic [15:0] src, input logic [15:0] dst);
        map_size  = 6'(s);
        map_count = 8'(maps);
        src_base  = src;
        dst_base  = dst;
        start     = 1'b1;
    endtask

    task automatic run_row(input vec_t v, input string tag);
        int unsigned win;
        int unsigned cyc;
        int unsigned rd0, pr0, ph0;
        rd_lat = v.rl; pool_lat = v.pl; wr_lat = v.wl;
        rd_q.delete();
        wr_q.delete();
        win = 0;
        if (!v.exp_err) push_model(v.size, v.maps, v.src, v.dst, win);
        rd0 = rd_seen; pr0 = pool_rise; ph0 = pool_hs;
        tick();
        drive_start(v.size, v.maps, v.src, v.dst);
        cyc = 1;
        do begin
            tick();
            start = 1'b0;
            // Configuration is free to change once the start cycle is over.
            map_size = 6'($urandom); map_count = 8'($urandom);
            src_base = 16'($urandom); dst_base = 16'($urandom);
            cyc++;
            if (cyc == 2) begin
                check({tag, ".busy_rise"}, busy, 1);
                check({tag, ".rd_req_rise"}, rd_req, !v.exp_err);
            end
        end while (!done && cyc < 4000);
        check({tag, ".done"}, done, 1);
        check({tag, ".cycles"}, cyc, v.cycles);
        check({tag, ".err"}, err, v.exp_err);
        check({tag, ".aborted"}, aborted, 0);
        check({tag, ".busy_at_done"}, busy, 1);
        check({tag, ".rd_left"}, rd_q.size(), 0);
        check({tag, ".wr_left"}, wr_q.size(), 0);
        check({tag, ".pool_starts"}, pool_rise - pr0, win);
        check({tag, ".pool_done"}, pool_hs - ph0, win);
        if (v.exp_err) check({tag, ".no_rd_req"}, rd_seen - rd0, 0);
`ifdef POOL_SEQ_PERF_EN
        check({tag, ".perf_stall"}, perf_stall, v.stall);
`endif
        tick();
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".busy_fall"}, busy, 0);
`ifdef POOL_SEQ_PERF_EN
        check({tag, ".perf_hold"}, perf_stall, v.stall);
`endif
    endtask

    initial begin
        int unsigned win;
        int unsigned k;
        int unsigned wseen;

        //           S   maps src       dst      rl pl wl err cycles stall
        vecs[0]  = '{4,  1, 16'h0100, 16'h0200, 0, 0, 0, 0, 18,   0};
        vecs[1]  = '{2,  3, 16'h0100, 16'h0200, 0, 0, 0, 0, 14,   0};
        vecs[2]  = '{2,  1, 16'h0100, 16'h0200, 3, 5, 0, 0, 14,   8};
        vecs[3]  = '{5,  1, 16'h0100, 16'h0200, 0, 0, 0, 1, 2,    0};
        vecs[4]  = '{4,  0, 16'h0100, 16'h0200, 0, 0, 0, 1, 2,    0};
        vecs[5]  = '{34, 1, 16'h0100, 16'h0200, 0, 0, 0, 1, 2,    0};
        vecs[6]  = '{0,  1, 16'h0100, 16'h0200, 0, 0, 0, 1, 2,    0};
        vecs[7]  = '{6,  2, 16'hFFF0, 16'hFFFE, 0, 0, 0, 0, 74,   0};
        vecs[8]  = '{4,  2, 16'h1000, 16'h3000, 1, 2, 1, 0, 66,   32};
        vecs[9]  = '{32, 1, 16'h0000, 16'h8000, 0, 0, 0, 0, 1026, 0};
        vecs[10] = '{8,  2, 16'h4000, 16'h5000, 0, 0, 0, 0, 130,  0};

        reset = 1'b0; start = 1'b0; abort = 1'b0;
        map_size = '0; map_count = '0; src_base = '0; dst_base = '0;
        rd_ack = 1'b0; pool_finish = 1'b0; wr_ack = 1'b0;
        repeat (3) tick();
        check("rst.rd_req", rd_req, 0);
        check("rst.pool_start", pool_start, 0);
        check("rst.wr_req", wr_req, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.err", err, 0);
        check("rst.aborted", aborted, 0);
        check("rst.rd_addr", rd_addr, 0);
        check("rst.wr_addr", wr_addr, 0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) run_row(vecs[i], $sformatf("vec%0d", i));

        // Abort while the pooling unit is busy on window 2 of 4.
        rd_lat = 0; pool_lat = 6; wr_lat = 0;
        rd_q.delete();
        wr_q.delete();
        push_model(4, 1, 16'h0100, 16'h0200, win);
        k = pool_rise;
        tick();
        drive_start(4, 1, 16'h0100, 16'h0200);
        tick();
        start = 1'b0;
        for (int n = 0; n < 100 && pool_rise - k < 2; n++) tick();
        check("abort.reach_pool2", pool_rise - k, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort.done", done, 1);
        check("abort.aborted", aborted, 1);
        check("abort.err", err, 0);
        check("abort.pool_start_drop", pool_start, 0);
        check("abort.reads_done", rd_q.size(), 2);
        check("abort.writes_left", wr_q.size(), 3);
        wseen = wr_seen;
        tick();
        check("abort.busy_fall", busy, 0);
        check("abort.done_pulse", done, 0);
        repeat (5) tick();
        check("abort.no_wr_req", wr_seen - wseen, 0);
        run_row(vecs[0], "after_abort");

        // Asynchronous reset while a write request is outstanding.
        rd_lat = 0; pool_lat = 0; wr_lat = 100;
        rd_q.delete();
        wr_q.delete();
        push_model(2, 1, 16'h0100, 16'h0200, win);
        tick();
        drive_start(2, 1, 16'h0100, 16'h0200);
        k = 0;
        do begin
            tick();
            start = 1'b0;
            k++;
        end while (!wr_req && k < 50);
        check("rstmid.wr_req_reached", wr_req, 1);
        #2 reset = 1'b0;
        #1;
        check("rstmid.rd_req", rd_req, 0);
        check("rstmid.pool_start", pool_start, 0);
        check("rstmid.wr_req", wr_req, 0);
        check("rstmid.busy", busy, 0);
        check("rstmid.done", done, 0);
        check("rstmid.err", err, 0);
        check("rstmid.aborted", aborted, 0);
        check("rstmid.rd_addr", rd_addr, 0);
        check("rstmid.wr_addr", wr_addr, 0);
        tick();
        reset = 1'b1;
        run_row(vecs[1], "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
